logicgate_pipe: RTL and testbench
=================================

LOGICGATE_PIPE -- requirements
Module: logicgate_pipe

Interface
REQ-001 Parameter WIDTH, 8, bit width of every operand and result.
REQ-002 Parameter CNT_W, 16, width of the completed-transaction counter.
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-005 Port in_valid  input  1  operand set on a, b, c and op is valid this cycle.
REQ-006 Port in_ready  output  1  block accepts the operand set this cycle.
REQ-007 Port a  input  WIDTH  operand A; the only operand used by NOT and BUF.
REQ-008 Port b  input  WIDTH  operand B.
REQ-009 Port c  input  WIDTH  operand C.
REQ-010 Port op  input  3  function select, encoded per REQ-016.
REQ-011 Port out_valid  output  1  y, y_zero and y_ones hold a valid result.
REQ-012 Port out_ready  input  1  downstream accepts the result this cycle.
REQ-013 Port y  output  WIDTH  bitwise result.
REQ-014 Port y_zero / y_ones  output  1 each  y is all-zeros / y is all-ones.
REQ-015 Port txn_count  output  CNT_W  number of results accepted downstream.

Function
REQ-016 op encoding:
- 0: AND3, a&b&c
- 1: OR3, a|b|c
- 2: NOT, ~a
- 3: NOR3, ~(a|b|c)
- 4: NAND3, ~(a&b&c)
- 5: XOR3, a^b^c
- 6: XNOR3, ~(a^b^c)
- 7: BUF, a
REQ-017 Two register stages:
- S1 captures a, b, c and op.
- S2 captures y, y_zero and y_ones computed from the S1 contents.
REQ-018 Input handshake: an operand set is accepted when in_valid and in_ready are both 1 in the same cycle.
REQ-019 Output handshake: a result is consumed when out_valid and out_ready are both 1 in the same cycle.
REQ-020 Latency: with no stall, the result is on y with out_valid=1 exactly 2 cycles after acceptance.
REQ-021 Throughput: with out_ready held at 1, one operand set is accepted every cycle.
REQ-022 S2 advance: S2 loads when it is empty or is being consumed this cycle.
REQ-023 S1 advance: S1 loads when it is empty or is advancing into S2 this cycle.
REQ-024 in_ready equals the S1 advance condition from REQ-023.
- in_ready is combinational from out_ready and the stage valid flags only.
- in_ready never depends on in_valid.
REQ-025 Backpressure:
- While out_ready=0, y, y_zero, y_ones and out_valid hold stable.
- With both stages full, in_ready=0.
- No result is dropped or duplicated.
REQ-026 Once out_valid=1 it remains 1 until the result is consumed.
REQ-027 Simultaneous events: consume from S2, S1-to-S2 transfer and new acceptance into S1 all complete in the same cycle.
REQ-028 txn_count increments by 1 on each output handshake and wraps from 2^CNT_W-1 to 0.
REQ-029 y_zero and y_ones are computed from the same S2 result as y; both are 0 for mixed bit patterns.
REQ-030 An op value applies only to its own operand set; op changes while stalled do not affect results already in flight.

Reset
REQ-031 While rst_n=0, all of the following hold immediately, independent of clk:
- S1 valid and S2 valid are 0.
- out_valid=0, y=0, y_zero=0, y_ones=0.
- txn_count=0.
REQ-032 Reset asserted mid-transfer discards all in-flight data; no result from before reset appears after it.
REQ-033 in_ready=1 in the first cycle after rst_n returns to 1, given out_ready is don't-care.

Structure
REQ-034 The shared package logicgate_pkg holds:
- the op enum type with the names of REQ-016;
- the constant OP_W=3.
REQ-035 A combinational sub-module logicgate_core computes y, y_zero and y_ones from a, b, c and op, parametrised by WIDTH.
REQ-036 The pipeline registers and handshake logic are implemented in logicgate_pipe.

Verification (WIDTH=8)
REQ-037 The bench covers these directed scenarios:
- Op sweep: a=8'hF0, b=8'hCC, c=8'hAA, op 0..7 back-to-back, out_ready=1. Required y in order: 80, FE, 0F, 01, 7F, 96, 69, F0. One result per cycle, first result 2 cycles after the first acceptance.
- Stall: out_ready=0 for 5 cycles with 3 sets offered. Exactly 2 are accepted, then in_ready=0. y holds the first result. After release, the results emerge in order and txn_count=3.
- Flags: op=0 with a=8'h00 gives y_zero=1, y_ones=0. op=1 with a=b=c=8'hFF gives y_ones=1, y_zero=0.
- Wrap: CNT_W=4, 17 results consumed, then txn_count=1.
- Reset mid-stream: rst_n low for one cycle with both stages full. out_valid drops immediately, txn_count=0, no stale result follows.
- Random: randomised in_valid/out_ready with a scoreboard. Zero mismatches over 10000 transactions.

Source files
------------

// File: rtl/logicgate_pkg.sv
// Shared definitions for the logic-gate pipeline: op encoding and widths.
package logicgate_pkg;

    localparam int OP_W = 3;

    // Function select carried alongside each operand set.
    typedef enum logic [OP_W-1:0] {
        AND3  = 3'd0,
        OR3   = 3'd1,
        NOT   = 3'd2,
        NOR3  = 3'd3,
        NAND3 = 3'd4,
        XOR3  = 3'd5,
        XNOR3 = 3'd6,
        BUF   = 3'd7
    } op_e;

endpackage

// File: rtl/logicgate_core.sv
// Combinational bitwise function unit with all-zeros / all-ones flags.
module logicgate_core
    import logicgate_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [WIDTH-1:0] i_c,
    input  logic [OP_W-1:0]  i_op,
    output logic [WIDTH-1:0] o_y,
    output logic             o_y_zero,
    output logic             o_y_ones
);

    op_e w_op;
    assign w_op = op_e'(i_op);

    // Select the bitwise function; NOT and BUF look only at operand A.
    always_comb begin
        o_y = '0;
        case (w_op)
            AND3:  o_y = i_a & i_b & i_c;
            OR3:   o_y = i_a | i_b | i_c;
            NOT:   o_y = ~i_a;
            NOR3:  o_y = ~(i_a | i_b | i_c);
            NAND3: o_y = ~(i_a & i_b & i_c);
            XOR3:  o_y = i_a ^ i_b ^ i_c;
            XNOR3: o_y = ~(i_a ^ i_b ^ i_c);
            BUF:   o_y = i_a;
        endcase
    end

    // Flags derive from the same result word, so mixed patterns give 0/0.
    assign o_y_zero = (o_y == '0);
    assign o_y_ones = &o_y;

endmodule

// File: rtl/logicgate_pipe.sv
// Two-stage valid/ready pipeline around logicgate_core.
// S1 holds the operand set, S2 holds the computed result and flags.
module logicgate_pipe
    import logicgate_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [OP_W-1:0]  op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             y_zero,
    output logic             y_ones,
    output logic [CNT_W-1:0] txn_count
);

    // Stage 1 state
    logic             r_s1_vld;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_c;
    logic [OP_W-1:0]  r_op;

    // Stage 2 state
    logic             r_s2_vld;
    logic [WIDTH-1:0] r_y;
    logic             r_y_zero;
    logic             r_y_ones;

    logic [CNT_W-1:0] r_cnt;

    logic             w_s2_adv;
    logic             w_s1_adv;
    logic             w_out_fire;
    logic [WIDTH-1:0] w_y;
    logic             w_y_zero;
    logic             w_y_ones;

    // Advance conditions ripple backwards from the output; in_valid is
    // deliberately absent so in_ready never loops through the source.
    assign w_out_fire = r_s2_vld & out_ready;
    assign w_s2_adv   = ~r_s2_vld | out_ready;
    assign w_s1_adv   = ~r_s1_vld | w_s2_adv;
    assign in_ready   = w_s1_adv;

    logicgate_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .i_a      (r_a),
        .i_b      (r_b),
        .i_c      (r_c),
        .i_op     (r_op),
        .o_y      (w_y),
        .o_y_zero (w_y_zero),
        .o_y_ones (w_y_ones)
    );

    // S1: capture operands and op whenever the stage can advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_vld <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_c      <= '0;
            r_op     <= '0;
        end else if (w_s1_adv) begin
            r_s1_vld <= in_valid;
            if (in_valid) begin
                r_a  <= a;
                r_b  <= b;
                r_c  <= c;
                r_op <= op;
            end
        end
    end

    // S2: capture the result; data holds while stalled so y stays stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_vld <= 1'b0;
            r_y      <= '0;
            r_y_zero <= 1'b0;
            r_y_ones <= 1'b0;
        end else if (w_s2_adv) begin
            r_s2_vld <= r_s1_vld;
            if (r_s1_vld) begin
                r_y      <= w_y;
                r_y_zero <= w_y_zero;
                r_y_ones <= w_y_ones;
            end
        end
    end

    // Count consumed results; wraps naturally at the counter width.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_out_fire) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign out_valid = r_s2_vld;
    assign y         = r_y;
    assign y_zero    = r_y_zero;
    assign y_ones    = r_y_ones;
    assign txn_count = r_cnt;

endmodule

// File: tb/tb_logicgate_pipe.sv
// Directed + randomized bench for logicgate_pipe. A second instance with a
// 4-bit counter shares the stimulus to exercise counter wrap.
module tb_logicgate_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a, b, c;
    logic [2:0]  op;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  y;
    logic        y_zero, y_ones;
    logic [15:0] txn_count;

    logic        w_in_ready, w_out_valid, w_y_zero, w_y_ones;
    logic [7:0]  w_y;
    logic [3:0]  w_txn;

    int checks   = 0;
    int failures = 0;

    logic [7:0] sweep_y [8] = '{8'h80, 8'hFE, 8'h0F, 8'h01, 8'h7F, 8'h96, 8'h69, 8'hF0};
    logic [7:0] q [$];

    logicgate_pipe #(.WIDTH(8), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c(c), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .y_zero(y_zero), .y_ones(y_ones), .txn_count(txn_count)
    );

    logicgate_pipe #(.WIDTH(8), .CNT_W(4)) u_wrap (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(w_in_ready),
        .a(a), .b(b), .c(c), .op(op), .out_valid(w_out_valid), .out_ready(out_ready),
        .y(w_y), .y_zero(w_y_zero), .y_ones(w_y_ones), .txn_count(w_txn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] model(input logic [7:0] ma, mb, mc, input logic [2:0] mop);
        case (mop)
            3'd0: return ma & mb & mc;
            3'd1: return ma | mb | mc;
            3'd2: return ~ma;
            3'd3: return ~(ma | mb | mc);
            3'd4: return ~(ma & mb & mc);
            3'd5: return ma ^ mb ^ mc;
            3'd6: return ~(ma ^ mb ^ mc);
            default: return ma;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        next();
        rst_n    = 1'b1;
    endtask

    initial begin
        int consumed;
        int cyc;
        logic       prev_stall;
        logic [7:0] prev_y;
        logic [7:0] e;

        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; c = '0; op = '0;

        // Async reset with clk low: outputs must clear without an edge
        #1 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_y", y, 0);
        chk("rst_y_zero", y_zero, 0);
        chk("rst_y_ones", y_ones, 0);
        chk("rst_txn", txn_count, 0);
        chk("rst_wrap_txn", w_txn, 0);
        next(); next();
        rst_n = 1'b1;
        sample();
        chk("rdy_after_rst", in_ready, 1);
        next();

        // Op sweep, back-to-back, no stall
        out_ready = 1'b1; a = 8'hF0; b = 8'hCC; c = 8'hAA;
        for (int k = 0; k < 10; k++) begin
            in_valid = (k < 8);
            op       = 3'(k);
            sample();
            chk("sweep_in_ready", in_ready, 1);
            if (k < 2) begin
                chk("sweep_latency_ov", out_valid, 0);
            end else begin
                chk("sweep_ov", out_valid, 1);
                chk("sweep_y", y, sweep_y[k-2]);
                chk("sweep_y_zero", y_zero, 0);
                chk("sweep_y_ones", y_ones, 0);
            end
            next();
        end
        in_valid = 1'b0;
        sample();
        chk("sweep_drained", out_valid, 0);
        chk("sweep_txn", txn_count, 8);
        next();

        // Stall: out_ready low, three sets offered, only two fit
        do_reset();
        out_ready = 1'b0; in_valid = 1'b1;
        a = 8'hF0; b = 8'hCC; c = 8'hAA; op = 3'd5;
        sample(); chk("stall_rdy0", in_ready, 1); next();
        op = 3'd0;
        sample(); chk("stall_rdy1", in_ready, 1); next();
        for (int j = 0; j < 3; j++) begin
            // Offered (not accepted) set wobbles; in-flight results must not
            op = (j == 1) ? 3'd7 : 3'd2;
            a  = (j == 1) ? 8'h00 : 8'hF0;
            sample();
            chk("stall_rdy_full", in_ready, 0);
            chk("stall_ov", out_valid, 1);
            chk("stall_y_hold", y, 8'h96);
            next();
        end
        out_ready = 1'b1;
        sample();
        chk("rel_rdy", in_ready, 1);
        chk("rel_y0", y, 8'h96);
        next();
        in_valid = 1'b0;
        sample(); chk("rel_ov1", out_valid, 1); chk("rel_y1", y, 8'h80); next();
        sample(); chk("rel_ov2", out_valid, 1); chk("rel_y2", y, 8'h0F); next();
        sample(); chk("rel_drained", out_valid, 0); chk("rel_txn", txn_count, 3);
        next();

        // Flags
        in_valid = 1'b1; op = 3'd0; a = 8'h00; b = 8'hFF; c = 8'hFF;
        next();
        op = 3'd1; a = 8'hFF; b = 8'hFF; c = 8'hFF;
        next();
        in_valid = 1'b0;
        sample();
        chk("flag_y0", y, 8'h00); chk("flag_zero", y_zero, 1); chk("flag_zero_ones", y_ones, 0);
        next();
        sample();
        chk("flag_yff", y, 8'hFF); chk("flag_ones", y_ones, 1); chk("flag_ones_zero", y_zero, 0);
        next();

        // Wrap: 17 results through a 4-bit counter
        do_reset();
        out_ready = 1'b1; in_valid = 1'b1; op = 3'd7;
        for (int k = 0; k < 17; k++) begin
            a = 8'(k);
            next();
        end
        in_valid = 1'b0;
        next(); next(); next();
        sample();
        chk("wrap_txn4", w_txn, 1);
        chk("wrap_txn16", txn_count, 17);
        next();

        // Reset mid-stream with both stages full
        out_ready = 1'b0; in_valid = 1'b1; op = 3'd5; a = 8'h11; b = 8'h22; c = 8'h44;
        next(); next();
        in_valid = 1'b0;
        sample();
        chk("mid_full_ov", out_valid, 1);
        chk("mid_full_rdy", in_ready, 0);
        next();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ov", out_valid, 0);
        chk("mid_rst_txn", txn_count, 0);
        chk("mid_rst_y", y, 0);
        chk("mid_rst_wrap_txn", w_txn, 0);
        next();
        rst_n = 1'b1; out_ready = 1'b1;
        sample();
        chk("mid_post_rdy", in_ready, 1);
        for (int k = 0; k < 3; k++) begin
            sample();
            chk("mid_no_stale", out_valid, 0);
            next();
        end

        // Random traffic against a scoreboard
        do_reset();
        consumed = 0; cyc = 0; prev_stall = 1'b0; prev_y = '0;
        while (consumed < 10000 && cyc < 40000) begin
            in_valid  = ($urandom_range(3) != 0);
            out_ready = ($urandom_range(3) != 0);
            a  = 8'($urandom);
            b  = 8'($urandom);
            c  = 8'($urandom);
            op = 3'($urandom_range(7));
            sample();
            if (prev_stall) begin
                chk("rnd_hold_ov", out_valid, 1);
                chk("rnd_hold_y", y, prev_y);
            end
            if (in_valid && in_ready) q.push_back(model(a, b, c, op));
            if (out_valid && out_ready) begin
                chk("rnd_q_nonempty", 32'(q.size() != 0), 1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    chk("rnd_y", y, e);
                    chk("rnd_y_zero", y_zero, 32'(e == 8'h00));
                    chk("rnd_y_ones", y_ones, 32'(e == 8'hFF));
                end
                consumed++;
            end
            prev_stall = out_valid && !out_ready;
            prev_y     = y;
            next();
            cyc++;
        end
        chk("rnd_consumed", consumed, 10000);
        in_valid = 1'b0;
        sample();
        chk("rnd_txn", txn_count, 10000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
